edge_pipe_sched: RTL and testbench

Sequences the edge-detector kernel chain (e.g. blur, gradient, edge_thin, threshold) over shared frame buffers. Each kernel is a run/done full-frame sweep whose pixel counter clears only on reset. This block resets each enabled kernel, runs it to completion, and steers source/destination frame-buffer selects. Buffer 0 holds the input image; buffers 1 and 2 are ping-ponged between stages. A per-stage watchdog and external abort are supported.

---
 rtl/edge_pipe_sched.sv | 190 +++++++++++++++++++
 tb/tb_edge_pipe_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_pipe_sched.sv
// Sequences a chain of run/done frame kernels over ping-ponged frame buffers.
// Latency: per enabled stage 1 clear + P run + 1 advance cycle, then a 1-cycle done pulse.
// No backpressure: start is ignored while busy; a stage stalls until its kernel reports done or the watchdog fires.
module edge_pipe_sched #(
    parameter int N_STAGES = 4,
    parameter int STG_BITS = 2,
    parameter int TIMEOUT  = 65536,
    parameter int TMO_BITS = 17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [N_STAGES-1:0] stage_en,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [1:0]          result_buf,
    output logic [STG_BITS-1:0] cur_stage,
    output logic [N_STAGES-1:0] stg_rst_n,
    output logic [N_STAGES-1:0] stg_run,
    input  logic [N_STAGES-1:0] stg_done,
    output logic [1:0]          src_sel,
    output logic [1:0]          dst_sel
);

    typedef enum logic [2:0] {IDLE, CLR, RUN, ADV, ABRT, FIN} state_t;

    state_t              state_q, state_d;
    logic [N_STAGES-1:0] mask_q, mask_d;
    logic [STG_BITS-1:0] cur_q, cur_d;
    logic [TMO_BITS-1:0] wd_q, wd_d;
    logic                err_q, err_d;
    logic [1:0]          res_q, res_d;
    logic [1:0]          src_q, src_d;
    logic [1:0]          dst_q, dst_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [N_STAGES-1:0] run_q, run_d;
    logic [N_STAGES-1:0] rstn_q, rstn_d;

    logic [STG_BITS-1:0] first_idx;
    logic                first_vld;
    logic [STG_BITS-1:0] nxt_idx;
    logic                nxt_vld;

    // Stage search: lowest bit of the incoming mask, and next enabled stage above the current one.
    always_comb begin
        first_idx = '0;
        first_vld = 1'b0;
        nxt_idx   = '0;
        nxt_vld   = 1'b0;
        for (int i = N_STAGES - 1; i >= 0; i--) begin
            if (stage_en[i]) begin
                first_idx = STG_BITS'(i);
                first_vld = 1'b1;
            end
            if (mask_q[i] && (i > int'(cur_q))) begin
                nxt_idx = STG_BITS'(i);
                nxt_vld = 1'b1;
            end
        end
    end

    // Next-state logic; outputs are derived from the next state so they register alongside it.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cur_d   = cur_q;
        wd_d    = wd_q;
        err_d   = err_q;
        res_d   = res_q;
        src_d   = src_q;
        dst_d   = dst_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    mask_d = stage_en;
                    err_d  = 1'b0;
                    src_d  = 2'd0;
                    dst_d  = 2'd1;
                    wd_d   = '0;
                    if (first_vld) begin
                        cur_d   = first_idx;
                        state_d = CLR;
                    end else begin
                        res_d   = 2'd0;
                        state_d = FIN;
                    end
                end
            end
            CLR: begin
                wd_d    = '0;
                state_d = abort ? ABRT : RUN;
            end
            RUN: begin
                wd_d = wd_q + 1'b1;
                if (abort) begin
                    state_d = ABRT;
                end else if (stg_done[cur_q]) begin
                    // The done cycle still carries the kernel's last write, so it wins over the watchdog.
                    state_d = ADV;
                end else if (wd_q == TMO_BITS'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ABRT;
                end
            end
            ADV: begin
                wd_d = '0;
                if (abort) begin
                    state_d = ABRT;
                end else begin
                    res_d = dst_q;
                    src_d = dst_q;
                    dst_d = 2'd3 - dst_q;
                    if (nxt_vld) begin
                        cur_d   = nxt_idx;
                        state_d = CLR;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            ABRT: begin
                // Only a watchdog error reports completion; a user abort returns silently.
                state_d = err_q ? FIN : IDLE;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
        run_d  = '0;
        rstn_d = '1;
        case (state_d)
            CLR:     rstn_d[cur_d] = 1'b0;
            RUN:     run_d[cur_d]  = 1'b1;
            ABRT:    rstn_d        = '0;
            default: ;
        endcase
    end

    // State and output registers with synchronous reset; kernels held in reset while rst is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            cur_q   <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            res_q   <= 2'd0;
            src_q   <= 2'd0;
            dst_q   <= 2'd1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            run_q   <= '0;
            rstn_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cur_q   <= cur_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            res_q   <= res_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            run_q   <= run_d;
            rstn_q  <= rstn_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign result_buf = res_q;
    assign cur_stage  = cur_q;
    assign stg_rst_n  = rstn_q;
    assign stg_run    = run_q;
    assign src_sel    = src_q;
    assign dst_sel    = dst_q;

endmodule

// File: tb/tb_edge_pipe_sched.sv
// Directed bench for edge_pipe_sched with stub run/done kernels.
// Latency checked per pass in cycles counted from the start cycle (cycle 0).
// Stub kernels never backpressure; one can be made to hang to exercise the watchdog.
module tb_edge_pipe_sched;

    localparam int NS  = 4;
    localparam int TMO = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [NS-1:0] stage_en;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    result_buf;
    logic [1:0]    cur_stage;
    logic [NS-1:0] stg_rst_n;
    logic [NS-1:0] stg_run;
    logic [NS-1:0] stg_done;
    logic [1:0]    src_sel;
    logic [1:0]    dst_sel;

    always #5 clk = ~clk;

    edge_pipe_sched #(
        .N_STAGES(NS),
        .STG_BITS(2),
        .TIMEOUT (TMO),
        .TMO_BITS(5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .stage_en  (stage_en),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .result_buf(result_buf),
        .cur_stage (cur_stage),
        .stg_rst_n (stg_rst_n),
        .stg_run   (stg_run),
        .stg_done  (stg_done),
        .src_sel   (src_sel),
        .dst_sel   (dst_sel)
    );

    // Stub kernels: pixel counter cleared by kernel reset, done on the last pixel while running.
    int         kcnt [NS];
    int         plen [NS];
    logic [NS-1:0] hang;

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (!stg_rst_n[i])   kcnt[i] <= 0;
            else if (stg_run[i]) kcnt[i] <= kcnt[i] + 1;
        end
    end

    always_comb begin
        for (int i = 0; i < NS; i++)
            stg_done[i] = stg_run[i] && !hang[i] && (kcnt[i] == plen[i] - 1);
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Per-pass observations
    int            done_cyc, abrt_cyc, idle_cyc, ndone, viol;
    logic          err_at_done, err_c1, sd_at_abort;
    logic [1:0]    res_at_done;
    logic [NS-1:0] ran, clrd;
    int            runcnt [NS];
    logic [1:0]    src_at [NS];
    logic [1:0]    dst_at [NS];

    task automatic run_pass(input logic [NS-1:0] en, input int abort_at, input int budget);
        int cyc;
        done_cyc = -1; abrt_cyc = -1; idle_cyc = -1; ndone = 0; viol = 0;
        err_at_done = 1'b0; err_c1 = 1'b1; sd_at_abort = 1'b0; res_at_done = 2'd3;
        ran = '0; clrd = '0;
        for (int i = 0; i < NS; i++) begin
            runcnt[i] = 0; src_at[i] = 2'd3; dst_at[i] = 2'd3;
        end
        @(negedge clk);
        start    = 1'b1;
        stage_en = en;
        @(negedge clk);
        start    = 1'b0;
        stage_en = ~en;
        cyc = 1;
        while (cyc <= budget) begin
            abort = (cyc == abort_at);
            if (cyc == abort_at) sd_at_abort = stg_done[1];
            if (cyc == 1) err_c1 = err;
            if (done) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc    = cyc;
                    err_at_done = err;
                    res_at_done = result_buf;
                end
            end
            if (busy && stg_rst_n == '0 && abrt_cyc < 0) abrt_cyc = cyc;
            if (busy) clrd |= ~stg_rst_n;
            if (!$onehot0(stg_run) || |(stg_run & ~stg_rst_n)) viol++;
            for (int i = 0; i < NS; i++) begin
                if (stg_run[i]) begin
                    if (runcnt[i] == 0) begin
                        src_at[i] = src_sel;
                        dst_at[i] = dst_sel;
                    end
                    runcnt[i]++;
                    ran[i] = 1'b1;
                end
            end
            if (!busy && idle_cyc < 0) idle_cyc = cyc;
            if (idle_cyc >= 0 && cyc >= idle_cyc + 3) break;
            @(negedge clk);
            cyc++;
        end
        abort = 1'b0;
    endtask

    typedef struct {
        logic [NS-1:0] en;
        int            done_cyc;
        logic [1:0]    res;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int k;
        vecs[0] = '{4'b1111, 73, 2'd2};
        vecs[1] = '{4'b0101, 37, 2'd2};
        vecs[2] = '{4'b0000,  1, 2'd0};
        vecs[3] = '{4'b0001, 19, 2'd1};
        vecs[4] = '{4'b1000, 19, 2'd1};
        vecs[5] = '{4'b0110, 37, 2'd2};
        vecs[6] = '{4'b0111, 55, 2'd1};

        for (int i = 0; i < NS; i++) plen[i] = 16;
        hang = '0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; stage_en = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_res", result_buf, 0);
        chk("rst_cur", cur_stage, 0);
        chk("rst_run", stg_run, 0);
        chk("rst_rstn", stg_rst_n, 4'b0000);
        chk("rst_src", src_sel, 0);
        chk("rst_dst", dst_sel, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_rstn", stg_rst_n, 4'b1111);
        chk("idle_busy", busy, 0);

        // Abort in IDLE suppresses start
        abort = 1'b1; start = 1'b1; stage_en = 4'b1111;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_rstn", stg_rst_n, 4'b1111);

        // Table-driven normal passes
        for (int v = 0; v < 7; v++) begin
            run_pass(vecs[v].en, -1, 200);
            chk($sformatf("v%0d_done_cyc", v), done_cyc, vecs[v].done_cyc);
            chk($sformatf("v%0d_ndone", v), ndone, 1);
            chk($sformatf("v%0d_idle_cyc", v), idle_cyc, vecs[v].done_cyc + 1);
            chk($sformatf("v%0d_res", v), res_at_done, vecs[v].res);
            chk($sformatf("v%0d_res_hold", v), result_buf, vecs[v].res);
            chk($sformatf("v%0d_err", v), err_at_done, 0);
            chk($sformatf("v%0d_ran", v), ran, vecs[v].en);
            chk($sformatf("v%0d_clrd", v), clrd, vecs[v].en);
            chk($sformatf("v%0d_viol", v), viol, 0);
            k = 0;
            for (int s = 0; s < NS; s++) begin
                if (vecs[v].en[s]) begin
                    chk($sformatf("v%0d_s%0d_runcnt", v, s), runcnt[s], 16);
                    chk($sformatf("v%0d_s%0d_src", v, s), src_at[s], (k == 0) ? 0 : ((k % 2 == 1) ? 1 : 2));
                    chk($sformatf("v%0d_s%0d_dst", v, s), dst_at[s], (k % 2 == 0) ? 1 : 2);
                    k++;
                end
            end
        end

        // Watchdog: stage 1 never finishes
        hang = 4'b0010;
        run_pass(4'b0011, -1, 200);
        chk("tmo_runcnt", runcnt[1], TMO);
        chk("tmo_abrt_cyc", abrt_cyc, 44);
        chk("tmo_done_cyc", done_cyc, 45);
        chk("tmo_err", err_at_done, 1);
        chk("tmo_ndone", ndone, 1);
        chk("tmo_err_hold", err, 1);
        hang = '0;
        run_pass(4'b0001, -1, 200);
        chk("tmo_err_clr", err_c1, 0);
        chk("tmo_next_done", done_cyc, 19);

        // Kernel done on the final watchdog cycle: done wins
        plen[0] = TMO;
        run_pass(4'b0001, -1, 200);
        chk("edge_runcnt", runcnt[0], TMO);
        chk("edge_done_cyc", done_cyc, TMO + 3);
        chk("edge_err", err_at_done, 0);
        plen[0] = 16;

        // Abort in the same cycle as stage 1 done
        run_pass(4'b0011, 35, 200);
        chk("abt_sd_same", sd_at_abort, 1);
        chk("abt_abrt_cyc", abrt_cyc, 36);
        chk("abt_idle_cyc", idle_cyc, 37);
        chk("abt_ndone", ndone, 0);
        chk("abt_err", err, 0);

        // start held high while busy, then reset mid-RUN
        @(negedge clk);
        start = 1'b1; stage_en = 4'b0001;
        @(negedge clk);
        chk("hold_clr_rstn", stg_rst_n, 4'b1110);
        @(negedge clk);
        chk("hold_run", stg_run, 4'b0001);
        @(negedge clk);
        chk("hold_norestart_rstn", stg_rst_n, 4'b1111);
        chk("hold_norestart_run", stg_run, 4'b0001);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_run", stg_run, 0);
        chk("mid_rst_rstn", stg_rst_n, 4'b0000);
        chk("mid_rst_dst", dst_sel, 1);
        chk("mid_rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rstn", stg_rst_n, 4'b1111);
        run_pass(4'b1111, -1, 200);
        chk("post_rst_done_cyc", done_cyc, 73);
        chk("post_rst_res", res_at_done, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
